mlp_result_collector: RTL and testbench

- Consumer end of the MLP output interface.
- Captures the stream of signed 16-bit neuron outputs produced by the inference core until the core raises finished.
- Tracks the running argmax (predicted class) and holds all captured values for ordered readback.
- Sits directly after the inference top level and feeds the result/report logic and the bench scoreboard.

---
 rtl/mlp_result_collector_if.sv | 28 ++
 rtl/mlp_result_collector.sv | 123 ++++++++++++
 tb/tb_mlp_result_collector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mlp_result_collector_if.sv
// MLP output stream plus collector result/readback bus.
// The master drives samples and read requests; the slave returns registered results.
interface mlp_result_collector_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 3
);
   logic [DATA_W-1:0] mlp_out;
   logic              mlp_valid;
   logic              mlp_finished;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [IDX_W-1:0]  argmax;
   logic [DATA_W-1:0] max_val;
   logic [IDX_W:0]    count;
   logic              done;
   logic              overflow;

   modport master (
      output mlp_out, mlp_valid, mlp_finished, rd_en,
      input  rd_data, rd_valid, argmax, max_val, count, done, overflow
   );

   modport slave (
      input  mlp_out, mlp_valid, mlp_finished, rd_en,
      output rd_data, rd_valid, argmax, max_val, count, done, overflow
   );
endinterface

// File: rtl/mlp_result_collector.sv
// Captures signed MLP outputs until finished, tracks running argmax, then serves ordered readback.
// All outputs registered; readback latency 1 cycle; no backpressure, excess samples dropped and flagged.
module mlp_result_collector #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3
) (
   input logic clk,
   input logic reset,
   mlp_result_collector_if.slave io
);
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W:0]    cnt;
   logic [IDX_W:0]    rd_ptr;
   logic [IDX_W-1:0]  argmax_q;
   logic [DATA_W-1:0] max_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              done_q;
   logic              ovf_q;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = '0;
      if (!reset && io.mlp_valid) begin
         if (state == IDLE) begin
            wr_en = 1'b1;
         end else if (state == COLLECT && cnt != DEPTH_C) begin
            wr_en  = 1'b1;
            wr_idx = cnt[IDX_W-1:0];
         end
      end
   end

   // Buffer contents need no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= io.mlp_out;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         rd_ptr     <= '0;
         argmax_q   <= '0;
         max_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (io.mlp_valid) begin
                  cnt      <= (IDX_W+1)'(1);
                  argmax_q <= '0;
                  max_q    <= io.mlp_out;
                  if (io.mlp_finished) begin
                     state  <= HOLD;
                     done_q <= 1'b1;
                  end else begin
                     state <= COLLECT;
                  end
               end else if (io.mlp_finished) begin
                  state    <= HOLD;
                  done_q   <= 1'b1;
                  cnt      <= '0;
                  argmax_q <= '0;
                  max_q    <= '0;
               end
            end
            COLLECT: begin
               if (io.mlp_valid) begin
                  if (cnt == DEPTH_C) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt <= cnt + (IDX_W+1)'(1);
                     // Strictly greater only, so ties keep the earlier index.
                     if ($signed(io.mlp_out) > $signed(max_q)) begin
                        max_q    <= io.mlp_out;
                        argmax_q <= cnt[IDX_W-1:0];
                     end
                  end
               end
               if (io.mlp_finished) begin
                  state  <= HOLD;
                  done_q <= 1'b1;
               end
            end
            HOLD: begin
               if (io.mlp_valid) begin
                  ovf_q <= 1'b1;
               end
               if (io.rd_en && rd_ptr < cnt) begin
                  rd_data_q  <= mem[rd_ptr[IDX_W-1:0]];
                  rd_valid_q <= 1'b1;
                  rd_ptr     <= rd_ptr + (IDX_W+1)'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.rd_data  = rd_data_q;
   assign io.rd_valid = rd_valid_q;
   assign io.argmax   = argmax_q;
   assign io.max_val  = max_q;
   assign io.count    = cnt;
   assign io.done     = done_q;
   assign io.overflow = ovf_q;
endmodule

// File: tb/tb_mlp_result_collector.sv
// Directed bench for mlp_result_collector: capture, argmax, overflow, readback and reset cases.
module tb_mlp_result_collector;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   mlp_result_collector_if #(.DATA_W(16), .IDX_W(3)) bus ();

   mlp_result_collector #(.DATA_W(16), .DEPTH(8), .IDX_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.mlp_out      = 16'h0000;
      bus.mlp_valid    = 1'b0;
      bus.mlp_finished = 1'b0;
      bus.rd_en        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [15:0] v);
      bus.mlp_out   = v;
      bus.mlp_valid = 1'b1;
      tick();
      bus.mlp_valid = 1'b0;
   endtask

   task automatic finish_pulse();
      bus.mlp_finished = 1'b1;
      tick();
      bus.mlp_finished = 1'b0;
   endtask

   task automatic read_one(input string tag, input logic vld, input logic [15:0] dat);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(bus.rd_valid), 32'(vld));
      chk({tag, "_dat"}, 32'(bus.rd_data), 32'(dat));
   endtask

   logic [15:0] s1_vals [4];
   logic [15:0] s4_vals [9];

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      idle_inputs();
      s1_vals = '{16'h0100, 16'hFF00, 16'h0280, 16'h0040};
      for (int i = 0; i < 9; i++) s4_vals[i] = 16'((i + 1) * 16);

      // Reset state
      do_reset();
      chk("rst_rd_data",  32'(bus.rd_data), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_argmax",   32'(bus.argmax), 0);
      chk("rst_max_val",  32'(bus.max_val), 0);
      chk("rst_count",    32'(bus.count), 0);
      chk("rst_done",     32'(bus.done), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);

      // Scenario 1: mixed-sign capture then finished
      for (int i = 0; i < 4; i++) send(s1_vals[i]);
      chk("s1_done_pre", 32'(bus.done), 0);
      finish_pulse();
      chk("s1_done",     32'(bus.done), 1);
      chk("s1_count",    32'(bus.count), 4);
      chk("s1_argmax",   32'(bus.argmax), 2);
      chk("s1_max_val",  32'(bus.max_val), 32'h0280);
      chk("s1_overflow", 32'(bus.overflow), 0);

      // Scenario 2: five back-to-back reads, fifth runs past the end
      bus.rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) begin
            chk("s2_rd_vld", 32'(bus.rd_valid), 1);
            chk("s2_rd_dat", 32'(bus.rd_data), 32'(s1_vals[i]));
         end else begin
            chk("s2_past_vld", 32'(bus.rd_valid), 0);
            chk("s2_past_dat", 32'(bus.rd_data), 32'h0040);
         end
      end
      bus.rd_en = 1'b0;
      tick();
      chk("s2_idle_vld", 32'(bus.rd_valid), 0);

      // Late sample and finished in HOLD: dropped, results frozen
      bus.mlp_finished = 1'b1;
      send(16'h7000);
      bus.mlp_finished = 1'b0;
      chk("hold_late_ovf",   32'(bus.overflow), 1);
      chk("hold_late_count", 32'(bus.count), 4);
      chk("hold_late_max",   32'(bus.max_val), 32'h0280);
      chk("hold_done",       32'(bus.done), 1);

      // Scenario 3: all negative with a tie
      do_reset();
      send(16'hFF80);
      send(16'hFE00);
      send(16'hFF80);
      finish_pulse();
      chk("s3_argmax",  32'(bus.argmax), 0);
      chk("s3_max_val", 32'(bus.max_val), 32'hFF80);
      chk("s3_count",   32'(bus.count), 3);

      // Scenario 4: nine samples into eight entries
      do_reset();
      for (int i = 0; i < 8; i++) send(s4_vals[i]);
      chk("s4_ovf_pre", 32'(bus.overflow), 0);
      send(s4_vals[8]);
      finish_pulse();
      chk("s4_count",   32'(bus.count), 8);
      chk("s4_ovf",     32'(bus.overflow), 1);
      chk("s4_argmax",  32'(bus.argmax), 7);
      chk("s4_max_val", 32'(bus.max_val), 32'h0080);
      for (int i = 0; i < 8; i++) read_one("s4_rd", 1'b1, s4_vals[i]);
      read_one("s4_rd_end", 1'b0, s4_vals[7]);

      // Scenario 5: last sample coincides with finished; rd_en ignored while collecting
      do_reset();
      send(16'h0100);
      bus.rd_en = 1'b1;
      send(16'h0200);
      bus.rd_en = 1'b0;
      chk("s5_rd_in_collect", 32'(bus.rd_valid), 0);
      bus.mlp_finished = 1'b1;
      send(16'h7FFF);
      bus.mlp_finished = 1'b0;
      chk("s5_done",    32'(bus.done), 1);
      chk("s5_count",   32'(bus.count), 3);
      chk("s5_argmax",  32'(bus.argmax), 2);
      chk("s5_max_val", 32'(bus.max_val), 32'h7FFF);
      read_one("s5_rd0", 1'b1, 16'h0100);

      // Scenario 6: reset mid-collect with a coincident sample
      do_reset();
      send(16'h0500);
      send(16'h0600);
      send(16'h0700);
      reset         = 1'b1;
      bus.mlp_out   = 16'h0800;
      bus.mlp_valid = 1'b1;
      tick();
      reset         = 1'b0;
      bus.mlp_valid = 1'b0;
      chk("s6_rst_count", 32'(bus.count), 0);
      chk("s6_rst_max",   32'(bus.max_val), 0);
      send(16'h0020);
      send(16'h0030);
      finish_pulse();
      chk("s6_count",   32'(bus.count), 2);
      chk("s6_ovf",     32'(bus.overflow), 0);
      chk("s6_argmax",  32'(bus.argmax), 1);
      chk("s6_max_val", 32'(bus.max_val), 32'h0030);
      read_one("s6_rd0", 1'b1, 16'h0020);
      read_one("s6_rd1", 1'b1, 16'h0030);
      read_one("s6_rd2", 1'b0, 16'h0030);

      // Finished with no samples from IDLE
      do_reset();
      finish_pulse();
      chk("empty_done",  32'(bus.done), 1);
      chk("empty_count", 32'(bus.count), 0);
      read_one("empty_rd", 1'b0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
